// File: rtl/rr_resource_arbiter.sv
// rr_resource_arbiter: round-robin owner arbiter with a one-cycle turnaround gap between owners.
// Define ARB_TIMEOUT_EN to forcibly revoke grants held for TIMEOUT_CYC cycles.
module rr_resource_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               rel,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               busy,
    output logic               timeout_evt
);
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
    localparam logic [ID_W:0] N = (ID_W + 1)'(NUM_REQ);
    state_t state, state_nx;
    logic [ID_W-1:0] ptr, owner, off, win, ptr_nx;
    logic [NUM_REQ-1:0] rot, own_oh;
    logic [ID_W:0] sum;
    logic any_req, own_req, ext, tmo;
    generate
        if (NUM_REQ < 2 || NUM_REQ > 16 || (1 << ID_W) < NUM_REQ || TIMEOUT_CYC < 2) begin : g_bad_cfg
            $error("rr_resource_arbiter: illegal parameter set");
        end
    endgenerate
    // rotate so bit 0 is the priority holder; the lowest set bit is the winner's offset
    always_comb begin
        rot = NUM_REQ'({req, req} >> ptr);
        any_req = |rot;
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (rot[i]) off = ID_W'(i);
        sum = {1'b0, ptr} + {1'b0, off};
        win = (sum >= N) ? ID_W'(sum - N) : sum[ID_W-1:0];
    end
    assign own_oh  = NUM_REQ'(1) << owner;
    assign own_req = |(req & own_oh);
    assign ext     = rel | ~own_req;
    assign ptr_nx  = (owner == ID_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC) + 1;
    logic [CW-1:0] cnt;
    logic tevt;
    // an in-cycle release wins over the terminal count
    assign tmo = ~ext & (cnt == CW'(TIMEOUT_CYC - 1));
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt  <= '0;
            tevt <= 1'b0;
        end else begin
            cnt  <= (state == GRANT) ? cnt + 1'b1 : '0;
            tevt <= (state == GRANT) & tmo;
        end
    assign timeout_evt = tevt;
`else
    assign tmo         = 1'b0;
    assign timeout_evt = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && any_req) owner <= win;
            if (state == GRANT && state_nx == GAP) ptr <= ptr_nx;
        end
    always_comb
        state_nx = (state == IDLE)  ? (any_req ? GRANT : IDLE) :
                   (state == GRANT) ? ((ext | tmo) ? GAP : GRANT) : IDLE;
    always_comb begin
        busy   = (state == GRANT);
        gnt    = busy ? own_oh : '0;
        gnt_id = busy ? owner : '0;
    end
endmodule

// File: doc/rr_resource_arbiter.md
Name: rr_resource_arbiter

Overview:
- Round-robin arbiter/controller that shares one datapath resource between NUM_REQ requesters.
- Grants exclusive ownership to one requester at a time and holds the grant until the owner releases it.
- Inserts a one-cycle turnaround gap between owners, then rotates priority.
- Sits between the requesting engines and the shared datapath; gnt_id drives the datapath input mux select.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, 2, width of gnt_id; must satisfy 2**ID_W >= NUM_REQ.
- TIMEOUT_CYC, 16, maximum grant length in cycles; used only with ARB_TIMEOUT_EN.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  request level per requester; held high until granted and used.
- rel  input  1  release pulse from the current owner; ignored unless state is GRANT.
- gnt  output  NUM_REQ  one-hot grant, registered.
- gnt_id  output  ID_W  binary index of the current owner; valid while busy=1.
- busy  output  1  high while any grant is active.
- timeout_evt  output  1  one-cycle pulse when a grant is forcibly revoked; tied 0 when the feature is absent.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, gnt=0, gnt_id=0, busy=0, timeout_evt=0.
  - Priority pointer ptr=0.
  - Reset mid-grant drops gnt immediately, with no turnaround gap.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If any req bit is set, select the first set bit scanning ptr, ptr+1, ... modulo NUM_REQ. This index is the winner.
  - Next edge: gnt[winner]=1, gnt_id=winner, busy=1, state=GRANT.
  - Latency is one cycle from req sampled high to gnt high.
  - If no req bit is set, stay in IDLE with all outputs 0.
- GRANT: gnt stays stable until one of two exit conditions occurs.
  - Normal exit: rel=1.
  - Abandon exit: req[gnt_id]=0.
  - On either exit, the next edge sets gnt=0, busy=0, ptr=(gnt_id+1) mod NUM_REQ, state=GAP.
  - rel and a req drop in the same cycle count as one exit; no double action.
- GAP:
  - Exactly one cycle with gnt=0. The resource drains/settles here.
  - Next state is always IDLE. Arbitration resumes in IDLE, so there are at least 2 idle-grant cycles between owners.
- Pointer wrap: when gnt_id=NUM_REQ-1, ptr wraps to 0.
- Fairness: a requester holding req continuously is granted within NUM_REQ arbitration rounds.
- rel asserted in IDLE or GAP is ignored and has no side effect.
- req bits for indices >= NUM_REQ do not exist; gnt_id never exceeds NUM_REQ-1.
- Invariants:
  - gnt is always zero or one-hot.
  - busy equals |gnt.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter of width $clog2(TIMEOUT_CYC)+1 clears on entry to GRANT and increments every GRANT cycle.
  - If the counter reaches TIMEOUT_CYC-1 with no rel and the owner's req still high, the next edge forces exit exactly like a release (gnt=0, ptr advance, GAP).
  - timeout_evt=1 for that single cycle, coincident with gnt falling.
  - An in-cycle rel at the terminal count takes precedence: normal exit, no timeout_evt.
- Without the macro: no counter, grants are unbounded, timeout_evt is constant 0.

Test Plan:
- Reset, then req=4'b0100 held -> gnt=4'b0100 and gnt_id=2 one cycle later; rel pulse -> gnt=0 next edge, one GAP cycle, ptr=3.
- req=4'b1111 held, rel pulsed 1 cycle after each grant -> grant order 0,1,2,3,0; each grant separated by gnt=0 for 2 cycles.
- ptr=3 (after a grant to 2), req=4'b0011 -> grant goes to 0, not 1; the next grant after release goes to 1.
- Owner 1 drops req with no rel -> gnt=0 next edge, ptr=2; rel pulsed in IDLE -> no state change.
- With ARB_TIMEOUT_EN, TIMEOUT_CYC=16, owner 0 never releases -> gnt[0] high for exactly 16 cycles, then timeout_evt=1 for 1 cycle and gnt falls; rel at cycle 16 instead -> no timeout_evt.
- rst_n pulled low mid-GRANT -> gnt, busy and gnt_id go to 0 asynchronously; after release, req=4'b1000 -> grant to 3 (ptr was reset to 0).
